line_buffer_nrow: RTL and testbench
===================================

// Module: line_buffer_nrow
// PURPOSE
//  Parametrised N-tap raster line buffer for the IR pixel pipeline. It sits between the sensor/frame stream and the NxN window filters.
//  Stores the previous rows in a ring of dual-port RAMs and emits a vertical column of P_LINES pixels per accepted pixel.
//  Successor to the single-row buffer: configurable taps and row length, frame resync, priming status and optional top-edge replication.
// PARAMETERS
//  P_ROW_WIDTH   256  pixels per row; must be >= 2 and <= 2**P_ADDR_WIDTH
//  P_DATA_WIDTH  8    bits per pixel
//  P_ADDR_WIDTH  12   RAM/column address width
//  P_LINES       3    taps per output column (current row + P_LINES-1 previous rows); must be >= 2
// PORTS
//  i_clk    in   1                      single clock, all logic and RAM ports
//  i_rst_n  in   1                      asynchronous active-low reset
//  i_sof    in   1                      start of frame; qualified by i_valid
//  i_valid  in   1                      pixel accepted this cycle (no backpressure)
//  i_data   in   P_DATA_WIDTH           pixel, raster order
//  o_valid  out  1                      o_taps/o_col valid
//  o_taps   out  P_LINES*P_DATA_WIDTH   tap k at [k*W +: W]; k=0 is current row, k=P_LINES-1 is oldest
//  o_col    out  P_ADDR_WIDTH           column of the emitted tap column
//  o_sol    out  1                      o_valid and o_col==0
//  o_eol    out  1                      o_valid and o_col==P_ROW_WIDTH-1
//  o_primed out  1                      P_LINES-1 full rows stored since the last SOF/reset
// BEHAVIOUR
//  Reset: all outputs 0; col=0, wsel=0, rows_filled=0. RAM contents are not cleared.
//  Storage: P_LINES RAMs, one row each. Current row written to RAM[wsel] at addr col; other P_LINES-1 RAMs read at addr col. No same-RAM read/write collision.
//  Tap mapping: tap k (k>=1) = RAM[(wsel-k) mod P_LINES] read data.
//  Latency: 2 cycles, i_valid -> o_valid (cycle 1 RAM read + i_data/col delay; cycle 2 output register). Throughput 1 pixel/cycle, gaps allowed.
//  Column counter: increments on i_valid; at P_ROW_WIDTH-1 wraps to 0, wsel advances mod P_LINES, rows_filled increments and saturates at P_LINES-1.
//  i_sof & i_valid: col, wsel, rows_filled forced to 0 before the pixel is used; the pixel is column 0 of row 0. A partial previous row is discarded.
//  i_sof without i_valid: ignored.
//  o_primed rises the cycle after rows_filled reaches P_LINES-1. Clears on accepted SOF or reset.
//  o_valid is the 2-cycle-delayed i_valid, gated by the primed state sampled with that pixel.
//  Pipeline holds its data when i_valid is low: o_taps keep their value; o_valid=0.
//  Async reset mid-row: pipeline flushed; stale RAM data is never emitted because priming restarts.
// CONFIGURATION
//  LB_EDGE_REPLICATE_EN defined: o_valid follows every accepted pixel from row 0.
//    Taps k > rows_filled(pixel) output tap rows_filled's value (top-border replication).
//    o_primed is unchanged.
//  LB_EDGE_REPLICATE_EN undefined: o_valid only for pixels accepted after priming. The first P_LINES-1 rows of each frame produce no output.
// STRUCTURE
//  Shared package lb_pkg:
//    - localparams LB_WSEL_W=$clog2(P_LINES) and LB_FILL_W=$clog2(P_LINES).
//    - function lb_tap_sel(wsel,k) returning the ring index.
//  Sub-module: P_LINES instances of custom_xpm_tdram (common_clock, depth P_ROW_WIDTH), generated in a for-generate.
//  Top holds the counters, delay pipeline and tap mux.
// TESTING (P_ROW_WIDTH=8, P_LINES=3, pixel = row*16+col)
//  1 Reset then stream 3 rows continuously:
//    - no o_valid for rows 0-1; o_primed=1 two cycles after pixel (1,7).
//    - pixel (2,3) -> 2 cycles later o_taps={0x03,0x13,0x23} (k2,k1,k0), o_col=3.
//  2 Continue to row 5:
//    - o_sol at col 0 and o_eol at col 7 each row.
//    - (5,7) gives taps {0x37,0x47,0x57}; wsel wrap exercised (5 rows > 3 RAMs).
//  3 Random i_valid gaps (50%) over rows 0-4:
//    - output sequence identical to scenario 2 in content.
//    - o_taps stable while o_valid=0.
//  4 SOF at (3,4) with i_valid:
//    - o_primed drops; pixel treated as (0,0).
//    - no output until new row 2; no pre-SOF data on any tap.
//  5 Assert i_rst_n=0 mid-row 3 for 1 cycle:
//    - all outputs 0 asynchronously.
//    - restreaming from row 0 behaves as scenario 1.
//  6 LB_EDGE_REPLICATE_EN:
//    - pixel (0,2) -> taps {0x02,0x02,0x02}.
//    - pixel (1,2) -> {0x02,0x02,0x12}.
//    - pixel (2,2) -> {0x02,0x12,0x22}.

Source files
------------

// File: rtl/lb_pkg.sv
// Shared sizing helpers and ring-index function for the N-tap line buffer.
package lb_pkg;

  localparam int unsigned LB_LINES_DEF = 3;
  localparam int unsigned LB_WSEL_W    = $clog2(LB_LINES_DEF);
  localparam int unsigned LB_FILL_W    = $clog2(LB_LINES_DEF);

  function automatic int unsigned lb_idx_w(input int unsigned lines);
    return (lines > 2) ? $clog2(lines) : 1;
  endfunction

  // RAM holding the row written k rows before the row currently in RAM[wsel].
  function automatic int lb_tap_sel(input int wsel, input int k, input int lines);
    return (wsel >= k) ? (wsel - k) : (wsel + lines - k);
  endfunction

endpackage

// File: rtl/custom_xpm_tdram.sv
// Single-clock (common_clock) dual-port RAM: port A writes, port B reads with one cycle latency.
// Contents are not initialised or reset.
module custom_xpm_tdram #(
  parameter int unsigned P_DEPTH      = 256,
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_ADDR_WIDTH = 12
) (
  input  logic                    i_clk,
  input  logic                    i_wea,
  input  logic [P_ADDR_WIDTH-1:0] i_addra,
  input  logic [P_DATA_WIDTH-1:0] i_dina,
  input  logic                    i_enb,
  input  logic [P_ADDR_WIDTH-1:0] i_addrb,
  output logic [P_DATA_WIDTH-1:0] o_doutb
);

  localparam int unsigned IdxW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

  logic [P_DATA_WIDTH-1:0] mem_q [P_DEPTH];
  logic [P_DATA_WIDTH-1:0] doutb_q, doutb_d;
  logic [IdxW-1:0]         idx_a, idx_b;

  assign idx_a = IdxW'(i_addra);
  assign idx_b = IdxW'(i_addrb);

  always_comb begin
    doutb_d = doutb_q;
    if (i_enb) doutb_d = mem_q[idx_b];
  end

  always_ff @(posedge i_clk) begin
    if (i_wea) mem_q[idx_a] <= i_dina;
    doutb_q <= doutb_d;
  end

  assign o_doutb = doutb_q;

endmodule

// File: rtl/line_buffer_nrow.sv
// N-tap raster line buffer: ring of row RAMs, emits a vertical column of P_LINES pixels per pixel.
// Optional LB_EDGE_REPLICATE_EN: emit from row 0 with top-border replication of missing taps.
module line_buffer_nrow
  import lb_pkg::*;
#(
  parameter int unsigned P_ROW_WIDTH  = 256,
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_ADDR_WIDTH = 12,
  parameter int unsigned P_LINES      = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_sof,
  input  logic                            i_valid,
  input  logic [P_DATA_WIDTH-1:0]         i_data,
  output logic                            o_valid,
  output logic [P_LINES*P_DATA_WIDTH-1:0] o_taps,
  output logic [P_ADDR_WIDTH-1:0]         o_col,
  output logic                            o_sol,
  output logic                            o_eol,
  output logic                            o_primed
);

  localparam int unsigned W     = P_DATA_WIDTH;
  localparam int unsigned WselW = lb_idx_w(P_LINES);
  localparam int unsigned FillW = WselW;
  localparam logic [P_ADDR_WIDTH-1:0] ColLast  = P_ADDR_WIDTH'(P_ROW_WIDTH - 1);
  localparam logic [WselW-1:0]        RingLast = WselW'(P_LINES - 1);

  logic [P_ADDR_WIDTH-1:0] col_q, col_d, col_eff;
  logic [WselW-1:0]        wsel_q, wsel_d, wsel_eff;
  logic [FillW-1:0]        fill_q, fill_d, fill_eff;
  logic                    primed_q, primed_d;
  logic                    frame_start;

  logic                    s1_valid_q, s1_valid_d;
  logic [W-1:0]            s1_data_q, s1_data_d;
  logic [P_ADDR_WIDTH-1:0] s1_col_q, s1_col_d;
  logic [WselW-1:0]        s1_wsel_q, s1_wsel_d;
  logic [FillW-1:0]        s1_fill_q, s1_fill_d;

  logic                            valid_q, valid_d;
  logic [P_LINES*W-1:0]            taps_q, taps_d;
  logic [P_ADDR_WIDTH-1:0]         ocol_q, ocol_d;
  logic                            sol_q, sol_d, eol_q, eol_d;
  logic                            emit;

  logic [W-1:0] rd_data [P_LINES];
  logic [W-1:0] tap_raw [P_LINES];
  logic [W-1:0] tap_out [P_LINES];

  // An accepted SOF restarts the frame before this pixel is stored.
  always_comb begin
    frame_start = i_valid & i_sof;
    col_eff     = frame_start ? '0 : col_q;
    wsel_eff    = frame_start ? '0 : wsel_q;
    fill_eff    = frame_start ? '0 : fill_q;
    col_d       = col_q;
    wsel_d      = wsel_q;
    fill_d      = fill_q;
    primed_d    = frame_start ? 1'b0 : (fill_q == RingLast);
    if (i_valid) begin
      if (col_eff == ColLast) begin
        col_d  = '0;
        wsel_d = (wsel_eff == RingLast) ? '0 : wsel_eff + WselW'(1);
        fill_d = (fill_eff == RingLast) ? fill_eff : fill_eff + FillW'(1);
      end else begin
        col_d  = col_eff + P_ADDR_WIDTH'(1);
        wsel_d = wsel_eff;
        fill_d = fill_eff;
      end
    end
  end

  for (genvar r = 0; r < P_LINES; r++) begin : g_ram
    custom_xpm_tdram #(
      .P_DEPTH     (P_ROW_WIDTH),
      .P_DATA_WIDTH(W),
      .P_ADDR_WIDTH(P_ADDR_WIDTH)
    ) u_ram (
      .i_clk  (i_clk),
      .i_wea  (i_valid && (wsel_eff == WselW'(r))),
      .i_addra(col_eff),
      .i_dina (i_data),
      .i_enb  (i_valid),
      .i_addrb(col_eff),
      .o_doutb(rd_data[r])
    );
  end

  always_comb begin
    s1_valid_d = i_valid;
    s1_data_d  = s1_data_q;
    s1_col_d   = s1_col_q;
    s1_wsel_d  = s1_wsel_q;
    s1_fill_d  = s1_fill_q;
    if (i_valid) begin
      s1_data_d = i_data;
      s1_col_d  = col_eff;
      s1_wsel_d = wsel_eff;
      s1_fill_d = fill_eff;
    end
  end

  always_comb begin
    for (int k = 0; k < int'(P_LINES); k++) begin
      if (k == 0) tap_raw[k] = s1_data_q;
      else        tap_raw[k] = rd_data[WselW'(lb_tap_sel(int'(s1_wsel_q), k, int'(P_LINES)))];
    end
    for (int k = 0; k < int'(P_LINES); k++) begin
`ifdef LB_EDGE_REPLICATE_EN
      // Rows above the frame top reuse the oldest row actually stored.
      tap_out[k] = (k > int'(s1_fill_q)) ? tap_raw[s1_fill_q] : tap_raw[k];
`else
      tap_out[k] = tap_raw[k];
`endif
    end
  end

`ifdef LB_EDGE_REPLICATE_EN
  assign emit = s1_valid_q;
`else
  assign emit = s1_valid_q & (s1_fill_q == RingLast);
`endif

  always_comb begin
    valid_d = emit;
    taps_d  = taps_q;
    ocol_d  = ocol_q;
    sol_d   = 1'b0;
    eol_d   = 1'b0;
    if (emit) begin
      for (int k = 0; k < int'(P_LINES); k++) taps_d[k*W +: W] = tap_out[k];
      ocol_d = s1_col_q;
      sol_d  = (s1_col_q == '0);
      eol_d  = (s1_col_q == ColLast);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q      <= '0;
      wsel_q     <= '0;
      fill_q     <= '0;
      primed_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_col_q   <= '0;
      s1_wsel_q  <= '0;
      s1_fill_q  <= '0;
      valid_q    <= 1'b0;
      taps_q     <= '0;
      ocol_q     <= '0;
      sol_q      <= 1'b0;
      eol_q      <= 1'b0;
    end else begin
      col_q      <= col_d;
      wsel_q     <= wsel_d;
      fill_q     <= fill_d;
      primed_q   <= primed_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_col_q   <= s1_col_d;
      s1_wsel_q  <= s1_wsel_d;
      s1_fill_q  <= s1_fill_d;
      valid_q    <= valid_d;
      taps_q     <= taps_d;
      ocol_q     <= ocol_d;
      sol_q      <= sol_d;
      eol_q      <= eol_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_taps   = taps_q;
  assign o_col    = ocol_q;
  assign o_sol    = sol_q;
  assign o_eol    = eol_q;
  assign o_primed = primed_q;

endmodule

// File: tb/tb_line_buffer_nrow.sv
// Self-checking bench for line_buffer_nrow (8-pixel rows, 3 taps, pixel = base + row*16 + col).
module tb_line_buffer_nrow;

  localparam int unsigned RowW  = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 12;
  localparam int unsigned Lines = 3;
`ifdef LB_EDGE_REPLICATE_EN
  localparam bit Rep = 1'b1;
`else
  localparam bit Rep = 1'b0;
`endif

  logic                  i_clk = 1'b0;
  logic                  i_rst_n = 1'b1;
  logic                  i_sof = 1'b0;
  logic                  i_valid = 1'b0;
  logic [DW-1:0]         i_data = '0;
  logic                  o_valid;
  logic [Lines*DW-1:0]   o_taps;
  logic [AW-1:0]         o_col;
  logic                  o_sol, o_eol, o_primed;

  typedef struct packed {
    logic [Lines*DW-1:0] taps;
    logic [AW-1:0]       col;
  } exp_t;

  exp_t                sbq[$];
  logic [Lines*DW-1:0] last_taps = '0;
  int                  n_total = 0;
  int                  n_pass = 0;

  line_buffer_nrow #(
    .P_ROW_WIDTH (RowW),
    .P_DATA_WIDTH(DW),
    .P_ADDR_WIDTH(AW),
    .P_LINES     (Lines)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sof   (i_sof),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_taps  (o_taps),
    .o_col   (o_col),
    .o_sol   (o_sol),
    .o_eol   (o_eol),
    .o_primed(o_primed)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // Reference column: tap k is frame row r-k, clamped to row 0 at the top border.
  function automatic logic [Lines*DW-1:0] model_taps(input int base, input int r, input int c);
    logic [Lines*DW-1:0] t;
    int rr;
    t = '0;
    for (int k = 0; k < int'(Lines); k++) begin
      rr = (r - k < 0) ? 0 : r - k;
      t[k*DW +: DW] = DW'(base + rr * 16 + c);
    end
    return t;
  endfunction

  // One clock of stimulus; scores whatever output the DUT presents after the edge.
  task automatic drive(input bit v, input bit sof, input int base, input int r, input int c);
    exp_t e;
    i_valid = v;
    i_sof   = sof;
    i_data  = v ? DW'(base + r * 16 + c) : DW'($urandom);
    if (v && (Rep || r >= int'(Lines) - 1))
      sbq.push_back('{taps: model_taps(base, r, c), col: AW'(c)});
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    if (o_valid) begin
      n_total++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_unexpected: got o_valid=1 col=%0d taps=%h, required no output",
                 o_col, o_taps);
      end else begin
        e = sbq.pop_front();
        last_taps = e.taps;
        if ({o_taps, o_col, o_sol, o_eol} !==
            {e.taps, e.col, e.col == '0, e.col == AW'(RowW - 1)})
          $display("FAIL sb_column: got taps=%h col=%0d sol=%b eol=%b, required taps=%h col=%0d",
                   o_taps, o_col, o_sol, o_eol, e.taps, e.col);
        else n_pass++;
      end
    end
  endtask

  task automatic flush(input string name);
    drive(1'b0, 1'b0, 0, 0, 0);
    drive(1'b0, 1'b0, 0, 0, 0);
    n_total++;
    if (sbq.size() != 0)
      $display("FAIL %s_drain: got %0d outputs missing, required 0", name, sbq.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    #3 i_rst_n = 1'b0;
    #2;
    n_total++;
    if ({o_valid, o_taps, o_col, o_sol, o_eol, o_primed} !== '0)
      $display("FAIL reset_outputs: got valid=%b taps=%h col=%0d primed=%b, required all 0",
               o_valid, o_taps, o_col, o_primed);
    else n_pass++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0);
    n_total++;
    if ({o_valid, o_taps, o_col, o_primed} !== '0)
      $display("FAIL reset_idle: got valid=%b taps=%h primed=%b, required all 0",
               o_valid, o_taps, o_primed);
    else n_pass++;
  endtask

  // Streams rows 0..last_row from reset state; checks priming and the (2,3) column.
  task automatic test_stream(input int last_row, input string name);
    for (int r = 0; r <= last_row; r++) begin
      for (int c = 0; c < int'(RowW); c++) begin
        drive(1'b1, 1'b0, 0, r, c);
        if (r == 1 && c == 7) begin
          n_total++;
          if (o_primed !== 1'b0) $display("FAIL %s_primed_early: got %b, required 0", name, o_primed);
          else n_pass++;
          drive(1'b0, 1'b0, 0, 0, 0);
          n_total++;
          if (o_primed !== 1'b1) $display("FAIL %s_primed_rise: got %b, required 1", name, o_primed);
          else n_pass++;
        end
        if (r == 1 && c == 3) begin
          n_total++;
          if (o_valid !== Rep) $display("FAIL %s_row1_valid: got %b, required %b", name, o_valid, Rep);
          else n_pass++;
        end
        if (r == 2 && c == 3) begin
          drive(1'b0, 1'b0, 0, 0, 0);
          n_total++;
          if ({o_valid, o_taps, o_col} !== {1'b1, 24'h031323, 12'd3})
            $display("FAIL %s_tap23: got valid=%b taps=%h col=%0d, required 1 031323 3",
                     name, o_valid, o_taps, o_col);
          else n_pass++;
        end
      end
    end
    if (last_row == 5) begin
      drive(1'b0, 1'b0, 0, 0, 0);
      n_total++;
      if ({o_valid, o_taps, o_col, o_eol} !== {1'b1, 24'h374757, 12'd7, 1'b1})
        $display("FAIL %s_tap57: got valid=%b taps=%h col=%0d eol=%b, required 1 374757 7 1",
                 name, o_valid, o_taps, o_col, o_eol);
      else n_pass++;
    end
    flush(name);
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 0, 0, 0);
    n_total++;
    if (o_primed !== 1'b1) $display("FAIL gaps_idle_sof: got primed=%b, required 1", o_primed);
    else n_pass++;
    for (int r = 0; r <= 4; r++) begin
      for (int c = 0; c < int'(RowW); c++) begin
        while ($urandom_range(0, 1) == 0) begin
          drive(1'b0, 1'b0, 0, 0, 0);
          if (!o_valid) begin
            n_total++;
            if (o_taps !== last_taps)
              $display("FAIL gaps_hold: got taps=%h, required %h", o_taps, last_taps);
            else n_pass++;
          end
        end
        drive(1'b1, (r == 0 && c == 0), 0, r, c);
      end
    end
    flush("gaps");
  endtask

  task automatic test_sof();
    for (int r = 0; r <= 3; r++)
      for (int c = 0; c < int'(RowW); c++)
        if (r < 3 || c < 4) drive(1'b1, (r == 0 && c == 0), 0, r, c);
    n_total++;
    if (o_primed !== 1'b1) $display("FAIL sof_primed_before: got %b, required 1", o_primed);
    else n_pass++;
    drive(1'b1, 1'b1, 8'h80, 0, 0);
    n_total++;
    if (o_primed !== 1'b0) $display("FAIL sof_primed_drop: got %b, required 0", o_primed);
    else n_pass++;
    for (int r = 0; r <= 2; r++)
      for (int c = 0; c < int'(RowW); c++)
        if (r > 0 || c > 0) drive(1'b1, 1'b0, 8'h80, r, c);
    flush("sof");
  endtask

  task automatic test_async_reset();
    for (int r = 0; r <= 3; r++)
      for (int c = 0; c < int'(RowW); c++)
        if (r < 3 || c < 4) drive(1'b1, (r == 0 && c == 0), 8'h40, r, c);
    #2 i_rst_n = 1'b0;
    #1;
    n_total++;
    if ({o_valid, o_taps, o_col, o_sol, o_eol, o_primed} !== '0)
      $display("FAIL arst_outputs: got valid=%b taps=%h col=%0d primed=%b, required all 0",
               o_valid, o_taps, o_col, o_primed);
    else n_pass++;
    sbq.delete();
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    test_stream(2, "arst");
  endtask

`ifdef LB_EDGE_REPLICATE_EN
  task automatic test_edge_replicate();
    logic [Lines*DW-1:0] want;
    for (int r = 0; r <= 2; r++) begin
      for (int c = 0; c < int'(RowW); c++) begin
        drive(1'b1, (r == 0 && c == 0), 0, r, c);
        if (c == 2) begin
          want = (r == 0) ? 24'h020202 : (r == 1) ? 24'h020212 : 24'h021222;
          drive(1'b0, 1'b0, 0, 0, 0);
          n_total++;
          if ({o_valid, o_taps} !== {1'b1, want})
            $display("FAIL rep_row%0d: got valid=%b taps=%h, required 1 %h", r, o_valid, o_taps, want);
          else n_pass++;
        end
      end
    end
    flush("rep");
  endtask
`endif

  initial begin
    test_reset();
    test_stream(5, "stream");
    test_gaps();
    test_sof();
    test_async_reset();
`ifdef LB_EDGE_REPLICATE_EN
    test_edge_replicate();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
